jk_excitation_ctrl: RTL and testbench
=====================================

Name: jk_excitation_ctrl

Overview:
- Drives the J/K inputs of a WIDTH-bit bank of jkff flops so the bank steps through a queue of target states, then reads back Q to confirm each step landed.
- Targets are pushed through a valid/ready port into an internal FIFO of DEPTH entries.
- Sits beside the sequential-circuit register banks as their excitation/sequencing controller.

Parameters:
- WIDTH, 4, number of JK flops driven (bits per target).
- DEPTH, 8, target FIFO entries; power of two, >= 2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_N  input  1  synchronous reset, active low.
- ENABLE  input  1  allows the controller to pop and apply targets.
- LOAD_VALID  input  1  target push request.
- LOAD_DATA  input  WIDTH  target state to push.
- LOAD_READY  output  1  FIFO not full.
- Q_FB  input  WIDTH  Q outputs of the driven flop bank.
- J  output  WIDTH  J drive to the flop bank, registered.
- K  output  WIDTH  K drive to the flop bank, registered.
- BUSY  output  1  state is not IDLE.
- DONE  output  1  one-cycle pulse: target verified.
- ERR  output  1  sticky readback-mismatch flag.
- ERR_MASK  output  WIDTH  bits that mismatched at the first error.
- ERR_CLR  input  1  clears ERR and ERR_MASK.
- COUNT  output  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-low on RESET_N.
- Reset (RESET_N low at a rising edge):
  - FIFO emptied, COUNT=0, state IDLE.
  - J=0, K=0, DONE=0, ERR=0, ERR_MASK=0.
  - LOAD_READY=1 in the cycle after reset.
  - Reset mid-operation abandons any in-flight target with no DONE pulse. The flop bank is not reset by this block.
- FIFO:
  - Push when LOAD_VALID && LOAD_READY. LOAD_READY = (COUNT != DEPTH), with no combinational bypass: a push while full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves COUNT unchanged.
  - Read/write pointers wrap modulo DEPTH.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - J=K=0.
  - If ENABLE && COUNT>0: pop the head into tgt, compute J/K from the current Q_FB and tgt, register them, and go to DRIVE.
- Excitation, per bit i, from q=Q_FB[i] and t=tgt[i]:
  - q==t -> J=0, K=0 (hold).
  - q=0, t=1 -> J=1, K=0.
  - q=1, t=0 -> J=0, K=1.
- DRIVE:
  - J/K are held for exactly this one cycle; the flop bank samples them at the closing edge.
  - Next state is CHECK, and J=K=0 is registered for it.
- CHECK:
  - Compare Q_FB with tgt.
  - Match: DONE=1 for the next cycle.
  - Mismatch: ERR=1 next cycle. ERR_MASK = Q_FB ^ tgt, captured only if ERR was 0; no DONE pulse.
  - Then, if ENABLE && COUNT>0, pop the next target (excitation computed from the current Q_FB) and go to DRIVE. Otherwise go to IDLE.
  - A mismatch does not stop sequencing.
- Timing: throughput is one target per 2 cycles. Latency from the pop edge to the DONE rising edge is 2 cycles.
- ENABLE deassert: takes effect only at the pop decision points (IDLE and CHECK). An in-flight DRIVE/CHECK pair always completes.
- ERR_CLR: clears ERR and ERR_MASK. If ERR_CLR and a new mismatch occur in the same cycle, the set wins and ERR_MASK takes the new mask.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: JK_TOGGLE_EN.
- When defined, a changing bit is driven J=1, K=1 (toggle) instead of 10/01; hold stays 00. Readback checking is unchanged, so a flop that missed a previous step is detected as a mismatch.
- When undefined, only the 00/10/01 codes are ever driven; 11 never appears on J/K.

Test Plan (WIDTH=4, DEPTH=8, bench drives a bank of 4 jkff with Q_FB=Q):
- Reset, then push 4'hA with ENABLE=1 from Q=0 -> DRIVE cycle J=1010, K=0000; Q=1010 next cycle; DONE pulses 2 cycles after the pop; ERR=0.
- Push 1010 then 0101 back-to-back -> second DRIVE J=0101, K=1010 (JK_TOGGLE_EN: J=K=1111); two DONE pulses 2 cycles apart; final Q=0101.
- Bench forces Q_FB[2] stuck at 0, target 0100 -> no DONE; ERR=1, ERR_MASK=0100. A second mismatch leaves the mask unchanged; ERR_CLR clears both to 0.
- ENABLE=0, push 9 targets -> 8 accepted, COUNT=8, LOAD_READY=0, 9th dropped. Set ENABLE=1 -> 8 DONE pulses; LOAD_READY rises after the first pop.
- Assert RESET_N=0 during a DRIVE cycle with 3 entries queued -> next cycle J=K=0, COUNT=0, BUSY=0, no DONE.
- Target equal to the current Q (e.g. 0011 twice) -> J=K=0000 in the second DRIVE; DONE still pulses.

Source files
------------

// File: rtl/jk_excitation_ctrl.sv
// jk_excitation_ctrl
// ------------------
// Excitation and sequencing controller for a WIDTH-bit bank of JK flops.
// Target states are queued in a DEPTH-entry FIFO. Each target is popped,
// turned into registered J/K drive for one cycle, and then checked against
// the bank's Q readback one cycle later.
//
// Optional build macro: JK_TOGGLE_EN
//   defined   : a changing bit is driven J=1,K=1 (toggle); hold stays 00.
//   undefined : only 00 / 10 / 01 are ever driven.
//
// Handshake: a target is accepted on a rising CLK edge where LOAD_VALID and
// LOAD_READY are both high. LOAD_READY depends only on the registered
// occupancy, so a push while full is dropped even if a pop happens in the
// same cycle.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RESET_N     synchronous reset, active low
//   ENABLE      allows targets to be popped and applied
//   LOAD_VALID  target push request
//   LOAD_DATA   target state to push
//   LOAD_READY  FIFO not full
//   Q_FB        Q readback of the driven flop bank
//   J, K        registered excitation drive to the flop bank
//   BUSY        controller is not IDLE
//   DONE        one-cycle pulse: target verified on readback
//   ERR         sticky readback-mismatch flag
//   ERR_MASK    mismatching bits captured at the first error
//   ERR_CLR     clears ERR and ERR_MASK
//   COUNT       FIFO occupancy
//   DBG_STATE   current FSM state (0 IDLE, 1 DRIVE, 2 CHECK)
module jk_excitation_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE,
  input  logic                     LOAD_VALID,
  input  logic [WIDTH-1:0]         LOAD_DATA,
  output logic                     LOAD_READY,
  input  logic [WIDTH-1:0]         Q_FB,
  output logic [WIDTH-1:0]         J,
  output logic [WIDTH-1:0]         K,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [WIDTH-1:0]         ERR_MASK,
  input  logic                     ERR_CLR,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [1:0]               DBG_STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] mask_q;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             mismatch;

  assign LOAD_READY = (count != FULL_COUNT);
  assign push       = LOAD_VALID && LOAD_READY;
  // Pops only happen at the two decision points; an in-flight DRIVE/CHECK
  // pair always runs to completion regardless of ENABLE.
  assign pop        = ((state == S_IDLE) || (state == S_CHECK)) &&
                      ENABLE && (count != '0);
  assign head       = mem[rd_ptr];
  assign mismatch   = (state == S_CHECK) && (Q_FB != tgt);

  // Excitation for the head target against the bank's present Q.
  always_comb begin
    chg   = Q_FB ^ head;
`ifdef JK_TOGGLE_EN
    exc_j = chg;
    exc_k = chg;
`else
    exc_j = chg & head;
    exc_k = chg & ~head;
`endif
  end

  // FIFO storage needs no reset; occupancy and pointers carry validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= LOAD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= S_IDLE;
      tgt    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // J/K and DONE are single-cycle unless a branch below sets them.
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            tgt   <= head;
            j_q   <= exc_j;
            k_q   <= exc_k;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (Q_FB == tgt) done_q <= 1'b1;
          if (pop) begin
            tgt   <= head;
            j_q   <= exc_j;
            k_q   <= exc_k;
            state <= S_DRIVE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // A new mismatch beats a simultaneous clear, and then its mask is
      // the one kept.
      if (mismatch) begin
        err_q <= 1'b1;
        if (!err_q || ERR_CLR) mask_q <= Q_FB ^ tgt;
      end else if (ERR_CLR) begin
        err_q  <= 1'b0;
        mask_q <= '0;
      end
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign BUSY      = (state != S_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_MASK  = mask_q;
  assign COUNT     = count;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_jk_excitation_ctrl.sv
// tb_jk_excitation_ctrl
// ---------------------
// Directed bench for jk_excitation_ctrl (WIDTH=4, DEPTH=8) driving a model
// bank of four JK flops whose Q feeds back to Q_FB. Accepted targets that
// are expected to verify go into exp_q; every DONE pulse pops one and
// compares it with the readback.
module tb_jk_excitation_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             enable;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;
  logic             err_clr;
  logic [3:0]       count;
  logic [1:0]       dbg_state;

  jk_excitation_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RESET_N    (reset_n),
    .ENABLE     (enable),
    .LOAD_VALID (load_valid),
    .LOAD_DATA  (load_data),
    .LOAD_READY (load_ready),
    .Q_FB       (q_fb),
    .J          (j),
    .K          (k),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .ERR_MASK   (err_mask),
    .ERR_CLR    (err_clr),
    .COUNT      (count),
    .DBG_STATE  (dbg_state)
  );

  // ---------------- flop bank model ----------------
  logic [WIDTH-1:0] q = '0;
  logic [WIDTH-1:0] stuck0 = '0;   // readback bits forced to 0
  assign q_fb = q & ~stuck0;

  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cq,
                                               input logic [WIDTH-1:0] cj,
                                               input logic [WIDTH-1:0] ck);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      case ({cj[i], ck[i]})
        2'b00:   r[i] = cq[i];
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        default: r[i] = ~cq[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) q <= jk_next(q, j, k);

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_without_target", {31'd0, done}, 32'd0);
      end else begin
        check("done_readback", {28'd0, q_fb}, {28'd0, exp_q.pop_front()});
      end
    end
`ifndef JK_TOGGLE_EN
    if ((j | k) != '0) check("no_jk_11", {28'd0, j & k}, 32'd0);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      nstep();
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  // Push one target that should mismatch and run it through to the ERR edge.
  task automatic run_mismatch(input logic [WIDTH-1:0] data);
    load_valid = 1'b1;
    load_data  = data;
    nstep();
    load_valid = 1'b0;
    nstep();
    nstep();
    nstep();
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] jexp;
  logic [WIDTH-1:0] kexp;
  logic [WIDTH-1:0] rnd;
  int mc;
  int base;

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    err_clr    = 1'b0;
    nstep();
    nstep();
    reset_n = 1'b1;

    // Reset state
    check("rst_j", {28'd0, j}, 32'd0);
    check("rst_k", {28'd0, k}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mask", {28'd0, err_mask}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd1);

    // Single target 1010 from Q=0000
    enable     = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'hA;
    exp_q.push_back(4'hA);
    nstep();
    load_valid = 1'b0;
    check("s1_count_after_push", {28'd0, count}, 32'd1);
    nstep();
    check("s1_drive_j", {28'd0, j}, 32'hA);
    check("s1_drive_k", {28'd0, k}, 32'h0);
    check("s1_drive_state", {30'd0, dbg_state}, 32'd1);
    check("s1_done_lat1", {31'd0, done}, 32'd0);
    nstep();
    check("s1_check_j", {28'd0, j}, 32'd0);
    check("s1_q", {28'd0, q_fb}, 32'hA);
    check("s1_done_lat2", {31'd0, done}, 32'd0);
    nstep();
    check("s1_done_pulse", {31'd0, done}, 32'd1);
    check("s1_err", {31'd0, err}, 32'd0);
    check("s1_idle", {31'd0, busy}, 32'd0);
    nstep();
    check("s1_done_end", {31'd0, done}, 32'd0);

    // Back-to-back 1010 then 0101 from Q=1010
`ifdef JK_TOGGLE_EN
    jexp = 4'hF;
    kexp = 4'hF;
`else
    jexp = 4'h5;
    kexp = 4'hA;
`endif
    load_valid = 1'b1;
    load_data  = 4'hA;
    exp_q.push_back(4'hA);
    nstep();
    load_data  = 4'h5;
    exp_q.push_back(4'h5);
    nstep();
    load_valid = 1'b0;
    check("s2_hold_j", {28'd0, j | k}, 32'd0);
    nstep();
    nstep();
    check("s2_second_j", {28'd0, j}, {28'd0, jexp});
    check("s2_second_k", {28'd0, k}, {28'd0, kexp});
    check("s2_first_done", {31'd0, done}, 32'd1);
    nstep();
    check("s2_gap", {31'd0, done}, 32'd0);
    nstep();
    check("s2_second_done", {31'd0, done}, 32'd1);
    check("s2_final_q", {28'd0, q_fb}, 32'h5);
    nstep();

    // Stuck readback bit: first mismatch captures the mask, later ones keep it
    stuck0 = 4'b0100;
    run_mismatch(4'b0100);
    check("s3_err_set", {31'd0, err}, 32'd1);
    check("s3_mask", {28'd0, err_mask}, 32'h4);
    check("s3_no_done", {31'd0, done}, 32'd0);
    nstep();
    stuck0 = 4'b0110;
    run_mismatch(4'b1110);
    check("s3_err_still", {31'd0, err}, 32'd1);
    check("s3_mask_kept", {28'd0, err_mask}, 32'h4);
    nstep();
    err_clr = 1'b1;
    nstep();
    err_clr = 1'b0;
    stuck0  = '0;
    check("s3_err_clr", {31'd0, err}, 32'd0);
    check("s3_mask_clr", {28'd0, err_mask}, 32'd0);

    // Fill with ENABLE=0: 8 accepted, 9th dropped
    enable = 1'b0;
    mc = 0;
    for (int i = 0; i < 9; i++) begin
      check("s4_ready", {31'd0, load_ready}, (mc != DEPTH) ? 32'd1 : 32'd0);
      rnd        = 4'($urandom_range(0, 15));
      load_valid = 1'b1;
      load_data  = rnd;
      if (mc < DEPTH) begin
        exp_q.push_back(rnd);
        mc++;
      end
      nstep();
    end
    load_valid = 1'b0;
    check("s4_full_count", {28'd0, count}, 32'd8);
    check("s4_full_ready", {31'd0, load_ready}, 32'd0);
    base   = done_cnt;
    enable = 1'b1;
    nstep();
    check("s4_ready_after_pop", {31'd0, load_ready}, 32'd1);
    check("s4_count_after_pop", {28'd0, count}, 32'd7);
    wait_dones(base + 8, 40, "s4_eight_dones");
    nstep();
    check("s4_drained", exp_q.size(), 32'd0);

    // Reset during DRIVE with 3 entries still queued
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd        = 4'($urandom_range(0, 15));
      load_valid = 1'b1;
      load_data  = rnd;
      nstep();
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    nstep();
    check("s5_in_drive", {30'd0, dbg_state}, 32'd1);
    check("s5_queued", {28'd0, count}, 32'd3);
    reset_n = 1'b0;
    nstep();
    reset_n = 1'b1;
    check("s5_j", {28'd0, j}, 32'd0);
    check("s5_k", {28'd0, k}, 32'd0);
    check("s5_count", {28'd0, count}, 32'd0);
    check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_ready", {31'd0, load_ready}, 32'd1);
    check("s5_no_done", {31'd0, done}, 32'd0);
    nstep();
    check("s5_no_done_late", {31'd0, done}, 32'd0);
    nstep();

    // Same target twice: second DRIVE is a hold
    base       = done_cnt;
    load_valid = 1'b1;
    load_data  = 4'b0011;
    exp_q.push_back(4'b0011);
    nstep();
    exp_q.push_back(4'b0011);
    nstep();
    load_valid = 1'b0;
    nstep();
    nstep();
    check("s6_hold_j", {28'd0, j}, 32'd0);
    check("s6_hold_k", {28'd0, k}, 32'd0);
    check("s6_busy", {31'd0, busy}, 32'd1);
    wait_dones(base + 2, 10, "s6_two_dones");
    nstep();
    check("s6_final_q", {28'd0, q_fb}, 32'h3);
    check("sb_empty", exp_q.size(), 32'd0);
    check("final_err", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
